regfile_master: RTL and testbench

- Initiator-side controller for the 32x32 register file: drives its write address/data and two read-address ports, and captures the read data.
- After reset it optionally clears all registers to zero.
- It then serves single read/write requests from a valid/ready request channel and returns results on a valid/ready response channel.
- Sits between the datapath/sequencer and registerfile, so no other block drives register-file ports.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_master.sv | 168 ++++++++++++++++
 tb/tb_regfile_master.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file initiator: default geometry,
// controller state encoding and the payload returned for write acknowledges.
package regfile_pkg;

    // Default register-file geometry (32 x 32-bit).
    localparam int unsigned DefDataW   = 32;
    localparam int unsigned DefAddrW   = 5;
    localparam int unsigned DefNumRegs = 32;

    // Controller states.
    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StWrite,
        StRead,
        StResp
    } masterState_e;

    // Data returned on both response lanes for a write acknowledge.
    localparam int unsigned WrAckData = 0;

endpackage

// File: rtl/regfile_master.sv
// Initiator-side controller for the register file. Optionally zeroes every
// register after reset, then serves one read or write request at a time from
// a valid/ready request channel and returns the result on a valid/ready
// response channel. All register-file and response outputs are registered.
module regfile_master
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W         = DefDataW,
    parameter int unsigned ADDR_W         = DefAddrW,
    parameter int unsigned NUM_REGS       = DefNumRegs,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    // Request channel
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr_a,
    input  logic [ADDR_W-1:0] req_addr_b,
    input  logic [DATA_W-1:0] req_wdata,

    // Response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,

    output logic              busy,

    // Register-file side
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr_a,
    output logic [ADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0] rf_rdata_a,
    input  logic [DATA_W-1:0] rf_rdata_b
);

    localparam masterState_e ResetState = CLEAR_ON_RESET ? StClear : StIdle;
    localparam logic [ADDR_W-1:0] LastReg = ADDR_W'(NUM_REGS - 1);
    localparam logic [DATA_W-1:0] AckData = DATA_W'(WrAckData);

    masterState_e      stateQ, stateD;
    logic [ADDR_W-1:0] clrCntQ, clrCntD;
    logic              weQ, weD;
    logic [ADDR_W-1:0] waddrQ, waddrD;
    logic [DATA_W-1:0] wdataQ, wdataD;
    logic [ADDR_W-1:0] raddrAQ, raddrAD;
    logic [ADDR_W-1:0] raddrBQ, raddrBD;
    logic              rspValidQ, rspValidD;
    logic [DATA_W-1:0] rspDataAQ, rspDataAD;
    logic [DATA_W-1:0] rspDataBQ, rspDataBD;

    // Next-state and registered-output logic for the controller FSM.
    always_comb begin
        stateD    = stateQ;
        clrCntD   = clrCntQ;
        weD       = 1'b0;
        waddrD    = waddrQ;
        wdataD    = wdataQ;
        raddrAD   = raddrAQ;
        raddrBD   = raddrBQ;
        rspValidD = rspValidQ;
        rspDataAD = rspDataAQ;
        rspDataBD = rspDataBQ;

        unique case (stateQ)
            StClear: begin
                weD     = 1'b1;
                waddrD  = clrCntQ;
                wdataD  = '0;
                clrCntD = clrCntQ + ADDR_W'(1);
                // Stop on the last register rather than wrapping the counter.
                if (clrCntQ == LastReg) begin
                    clrCntD = '0;
                    stateD  = StIdle;
                end
            end

            StIdle: begin
                if (req_valid) begin
                    if (req_write) begin
                        weD    = 1'b1;
                        waddrD = req_addr_a;
                        wdataD = req_wdata;
                        stateD = StWrite;
                    end else begin
                        raddrAD = req_addr_a;
                        raddrBD = req_addr_b;
                        stateD  = StRead;
                    end
                end
            end

            StWrite: begin
                rspDataAD = AckData;
                rspDataBD = AckData;
                rspValidD = 1'b1;
                stateD    = StResp;
            end

            // Register-file read is combinational; capture at the end of this cycle.
            StRead: begin
                rspDataAD = rf_rdata_a;
                rspDataBD = rf_rdata_b;
                rspValidD = 1'b1;
                stateD    = StResp;
            end

            StResp: begin
                if (rsp_ready) begin
                    rspValidD = 1'b0;
                    stateD    = StIdle;
                end
            end

            default: begin
                stateD = ResetState;
            end
        endcase
    end

    // State, clear counter and output registers; reset aborts any transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ    <= ResetState;
            clrCntQ   <= '0;
            weQ       <= 1'b0;
            waddrQ    <= '0;
            wdataQ    <= '0;
            raddrAQ   <= '0;
            raddrBQ   <= '0;
            rspValidQ <= 1'b0;
            rspDataAQ <= '0;
            rspDataBQ <= '0;
        end else begin
            stateQ    <= stateD;
            clrCntQ   <= clrCntD;
            weQ       <= weD;
            waddrQ    <= waddrD;
            wdataQ    <= wdataD;
            raddrAQ   <= raddrAD;
            raddrBQ   <= raddrBD;
            rspValidQ <= rspValidD;
            rspDataAQ <= rspDataAD;
            rspDataBQ <= rspDataBD;
        end
    end

    assign req_ready  = (stateQ == StIdle);
    assign busy       = (stateQ == StClear);
    assign rf_we      = weQ;
    assign rf_waddr   = waddrQ;
    assign rf_wdata   = wdataQ;
    assign rf_raddr_a = raddrAQ;
    assign rf_raddr_b = raddrBQ;
    assign rsp_valid  = rspValidQ;
    assign rsp_data_a = rspDataAQ;
    assign rsp_data_b = rspDataBQ;

    // A stalled response must keep its payload until it is consumed.
    rspStable: assert property (@(posedge clk) disable iff (!rst)
        (rspValidQ && !rsp_ready) |=> (rspValidQ && $stable(rspDataAQ) && $stable(rspDataBQ)));

endmodule

// File: tb/tb_regfile_master.sv
// Self-checking bench for regfile_master: a behavioural 32x32 register file
// sits on the rf_* ports, and an array-based reference model predicts every
// response from the accepted requests.
module tb_regfile_master;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 32;

    logic          clk;
    logic          rst;
    logic          req_valid, req_ready, req_write;
    logic [AW-1:0] req_addr_a, req_addr_b;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid, rsp_ready;
    logic [DW-1:0] rsp_data_a, rsp_data_b;
    logic          busy;
    logic          rf_we;
    logic [AW-1:0] rf_waddr, rf_raddr_a, rf_raddr_b;
    logic [DW-1:0] rf_wdata, rf_rdata_a, rf_rdata_b;

    // Register file the DUT drives, and the reference view of its contents.
    logic [DW-1:0] rfMem [NR];
    logic [DW-1:0] refMem [NR];
    logic          doPreload;

    int numVectors     = 0;
    int numMiscompares = 0;

    regfile_master #(
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .NUM_REGS      (NR),
        .CLEAR_ON_RESET(1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr_a(req_addr_a),
        .req_addr_b(req_addr_b),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data_a(rsp_data_a),
        .rsp_data_b(rsp_data_b),
        .busy      (busy),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .rf_raddr_a(rf_raddr_a),
        .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a),
        .rf_rdata_b(rf_rdata_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file: preload to all-ones on request, otherwise clocked write.
    always @(posedge clk) begin
        if (doPreload) begin
            for (int i = 0; i < NR; i++) rfMem[i] <= '1;
        end else if (rf_we) begin
            rfMem[rf_waddr] <= rf_wdata;
        end
    end

    assign rf_rdata_a = rfMem[rf_raddr_a];
    assign rf_rdata_b = rfMem[rf_raddr_b];

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        numVectors++;
        if (got !== exp) begin
            numMiscompares++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Follow a clear sequence from reset release until the controller is ready.
    task automatic checkClear();
        int busyCnt;
        int weCnt;
        bit reachedIdle;
        busyCnt     = 0;
        weCnt       = 0;
        reachedIdle = 1'b0;
        for (int k = 0; k < 48; k++) begin
            checkVal("clrRspValid", 32'(rsp_valid), 32'd0);
            if (busy) begin
                busyCnt++;
                checkVal("clrReqReady", 32'(req_ready), 32'd0);
            end
            if (rf_we) begin
                checkVal("clrWaddr", 32'(rf_waddr), 32'(weCnt));
                checkVal("clrWdata", rf_wdata, 32'd0);
                weCnt++;
            end
            if (req_ready) begin
                reachedIdle = 1'b1;
                break;
            end
            tick();
        end
        checkVal("clrIdle", 32'(reachedIdle), 32'd1);
        checkVal("clrBusyCycles", 32'(busyCnt), NR);
        checkVal("clrWeCycles", 32'(weCnt), NR);
        for (int i = 0; i < NR; i++) refMem[i] = '0;
    endtask

    // One request/response transaction, checked cycle by cycle from accept.
    task automatic doTxn(input bit wr, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] wd, input int holdOff);
        logic [DW-1:0] expA, expB;
        bit accepted;
        req_write  = wr;
        req_addr_a = a;
        req_addr_b = b;
        req_wdata  = wd;
        req_valid  = 1'b1;
        accepted   = 1'b0;
        for (int k = 0; k < 64; k++) begin
            if (req_ready) begin
                accepted = 1'b1;
                break;
            end
            tick();
        end
        checkVal("accept", 32'(accepted), 32'd1);
        if (!accepted) begin
            req_valid = 1'b0;
            return;
        end
        if (wr) begin
            refMem[a] = wd;
            expA = '0;
            expB = '0;
        end else begin
            expA = refMem[a];
            expB = refMem[b];
        end

        tick();  // T+1
        req_valid  = 1'b0;
        req_write  = 1'($urandom);
        req_addr_a = AW'($urandom);
        req_addr_b = AW'($urandom);
        req_wdata  = $urandom;
        checkVal("t1RspValid", 32'(rsp_valid), 32'd0);
        checkVal("t1ReqReady", 32'(req_ready), 32'd0);
        if (wr) begin
            checkVal("wrWe", 32'(rf_we), 32'd1);
            checkVal("wrWaddr", 32'(rf_waddr), 32'(a));
            checkVal("wrWdata", rf_wdata, wd);
        end else begin
            checkVal("rdWe", 32'(rf_we), 32'd0);
            checkVal("rdRaddrA", 32'(rf_raddr_a), 32'(a));
            checkVal("rdRaddrB", 32'(rf_raddr_b), 32'(b));
        end

        tick();  // T+2
        checkVal("t2RspValid", 32'(rsp_valid), 32'd1);
        checkVal("t2We", 32'(rf_we), 32'd0);
        checkVal(wr ? "wrAckA" : "rdDataA", rsp_data_a, expA);
        checkVal(wr ? "wrAckB" : "rdDataB", rsp_data_b, expB);

        for (int k = 0; k < holdOff; k++) begin
            rsp_ready = 1'b0;
            tick();
            checkVal("holdValid", 32'(rsp_valid), 32'd1);
            checkVal("holdDataA", rsp_data_a, expA);
            checkVal("holdDataB", rsp_data_b, expB);
            checkVal("holdReqReady", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checkVal("doneRspValid", 32'(rsp_valid), 32'd0);
        checkVal("doneReqReady", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit            wr;
        logic [AW-1:0] a, b;
        rst        = 1'b1;
        doPreload  = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr_a = '0;
        req_addr_b = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b0;

        // Reset with the register file preloaded to all-ones.
        #3 rst = 1'b0;
        doPreload = 1'b1;
        @(posedge clk);
        #1 doPreload = 1'b0;
        checkVal("rstBusy", 32'(busy), 32'd1);
        checkVal("rstReqReady", 32'(req_ready), 32'd0);
        checkVal("rstRspValid", 32'(rsp_valid), 32'd0);
        checkVal("rstRspDataA", rsp_data_a, 32'd0);
        checkVal("rstRspDataB", rsp_data_b, 32'd0);
        checkVal("rstWe", 32'(rf_we), 32'd0);
        checkVal("rstWaddr", 32'(rf_waddr), 32'd0);
        checkVal("rstWdata", rf_wdata, 32'd0);
        checkVal("rstRaddrA", 32'(rf_raddr_a), 32'd0);
        checkVal("rstRaddrB", 32'(rf_raddr_b), 32'd0);

        // A read is already pending when the clear starts; it must wait for IDLE.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr_a = AW'(31);
        req_addr_b = AW'(0);
        tick();
        rst = 1'b1;
        checkClear();
        doTxn(1'b0, AW'(31), AW'(0), '0, 0);

        // Directed transactions.
        doTxn(1'b1, AW'(4), AW'(0), 32'd7, 0);
        doTxn(1'b0, AW'(4), AW'(6), '0, 0);
        doTxn(1'b1, AW'(5), AW'(0), 32'd13, 0);
        doTxn(1'b0, AW'(5), AW'(5), '0, 0);
        doTxn(1'b0, AW'(4), AW'(5), '0, 10);
        doTxn(1'b1, AW'(0), AW'(0), 32'hDEAD_BEEF, 2);
        doTxn(1'b0, AW'(0), AW'(31), '0, 0);

        // Randomized traffic over a narrow address window to force reuse.
        for (int n = 0; n < 80; n++) begin
            wr = 1'($urandom);
            a  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            b  = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            doTxn(wr, a, b, $urandom, int'($urandom_range(0, 3)));
        end

        // Reset during the response of a read: response lost, clear restarts.
        req_write  = 1'b0;
        req_addr_a = AW'(4);
        req_addr_b = AW'(5);
        req_valid  = 1'b1;
        checkVal("midAccept", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        tick();
        checkVal("midRespValid", 32'(rsp_valid), 32'd1);
        rst = 1'b0;
        #1;
        checkVal("midRstRspValid", 32'(rsp_valid), 32'd0);
        checkVal("midRstRspDataA", rsp_data_a, 32'd0);
        checkVal("midRstBusy", 32'(busy), 32'd1);
        checkVal("midRstReqReady", 32'(req_ready), 32'd0);
        checkVal("midRstWe", 32'(rf_we), 32'd0);
        tick();
        rst = 1'b1;
        checkClear();
        doTxn(1'b0, AW'(4), AW'(5), '0, 0);
        doTxn(1'b0, AW'(0), AW'(7), '0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
